// File: rtl/alu_func_pkg.sv
// rtl/alu_func_pkg.sv - function codes and FSM state type for the EX-stage ALU
package alu_func_pkg;

    localparam logic [5:0] FUNC_SLL  = 6'b000000;
    localparam logic [5:0] FUNC_SRL  = 6'b000010;
    localparam logic [5:0] FUNC_SRA  = 6'b000011;
    localparam logic [5:0] FUNC_CLZ  = 6'b000111;
    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_XOR  = 6'b100110;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_SLT  = 6'b101010;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;
    localparam logic [5:0] FUNC_CLO  = 6'b111000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } alu_state_t;

    function automatic logic isCountFunc(input logic [5:0] f);
        return (f == FUNC_CLO) || (f == FUNC_CLZ);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - start/done request and result bus of the execution unit
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       func;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output start, func, op_a, op_b, shamt,
        input  busy, done, result, zero, overflow, illegal
    );

    modport slave (
        input  start, func, op_a, op_b, shamt,
        output busy, done, result, zero, overflow, illegal
    );
endinterface

// File: rtl/lead_counter.sv
// rtl/lead_counter.sv - iterative leading-ones/leading-zeros counter, one bit per cycle
module lead_counter #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             ones,
    output logic [CW-1:0]    count,
    output logic             finished
);

    logic [WIDTH-1:0] shiftReg;
    logic [CW-1:0]    cntReg;
    logic             onesReg;
    logic             match;

    // The bit under inspection is always the MSB of the shift copy.
    assign match    = (shiftReg[WIDTH-1] == onesReg);
    // Stop on the first mismatch, or when this match completes a full word.
    assign finished = !match || (cntReg == CW'(WIDTH - 1));
    // Count as it will stand once the current bit is accounted for.
    assign count    = match ? cntReg + CW'(1) : cntReg;

    // Load a fresh operand, otherwise consume one matching bit per cycle until finished.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shiftReg <= '0;
            cntReg   <= '0;
            onesReg  <= 1'b0;
        end else if (load) begin
            shiftReg <= value;
            cntReg   <= '0;
            onesReg  <= ones;
        end else if (!finished) begin
            shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
            cntReg   <= cntReg + CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle EX-stage ALU with start/done handshake
module alu_exec_unit
    import alu_func_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic        clk,
    input  logic        reset_n,
    alu_exec_if.slave   bus
);

    alu_state_t       state;
    alu_state_t       nextState;
    logic             accept;

    logic [5:0]       funcReg;
    logic [WIDTH-1:0] opAReg;
    logic [WIDTH-1:0] opBReg;
    logic [4:0]       shamtReg;

    logic [WIDTH-1:0] resultReg;
    logic             zeroReg;
    logic             overflowReg;
    logic             illegalReg;

    logic [WIDTH-1:0] execResult;
    logic             execOverflow;
    logic             execIllegal;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    logic [CW-1:0]    leadCount;
    logic             leadFinished;

    assign accept = (state == IDLE) && bus.start;

    lead_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) uLeadCounter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .value    (bus.op_a),
        .ones     (bus.func == FUNC_CLO),
        .count    (leadCount),
        .finished (leadFinished)
    );

    // State register; reset aborts any operation in flight, including a count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state selection: count codes iterate, everything else takes one EXEC cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nextState = isCountFunc(bus.func) ? COUNT : EXEC;
                end
            end
            EXEC:    nextState = DONE;
            COUNT:   nextState = leadFinished ? DONE : COUNT;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Capture the request only when it is accepted so later start pulses cannot disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            funcReg  <= '0;
            opAReg   <= '0;
            opBReg   <= '0;
            shamtReg <= '0;
        end else if (accept) begin
            funcReg  <= bus.func;
            opAReg   <= bus.op_a;
            opBReg   <= bus.op_b;
            shamtReg <= bus.shamt;
        end
    end

    assign sum  = opAReg + opBReg;
    assign diff = opAReg - opBReg;

    // Single-cycle datapath for the non-count codes; unknown codes yield zero and flag illegal.
    always_comb begin
        execResult   = '0;
        execOverflow = 1'b0;
        execIllegal  = 1'b0;
        case (funcReg)
            FUNC_ADD: begin
                execResult   = sum;
                execOverflow = (opAReg[WIDTH-1] == opBReg[WIDTH-1]) &&
                               (sum[WIDTH-1] != opAReg[WIDTH-1]);
            end
            FUNC_ADDU: execResult = sum;
            FUNC_SUB: begin
                execResult   = diff;
                execOverflow = (opAReg[WIDTH-1] != opBReg[WIDTH-1]) &&
                               (diff[WIDTH-1] != opAReg[WIDTH-1]);
            end
            FUNC_SUBU: execResult = diff;
            FUNC_AND:  execResult = opAReg & opBReg;
            FUNC_OR:   execResult = opAReg | opBReg;
            FUNC_XOR:  execResult = opAReg ^ opBReg;
            FUNC_NOR:  execResult = ~(opAReg | opBReg);
            FUNC_SLT:  execResult = {{(WIDTH-1){1'b0}}, ($signed(opAReg) < $signed(opBReg))};
            FUNC_SLTU: execResult = {{(WIDTH-1){1'b0}}, (opAReg < opBReg)};
            FUNC_SLL:  execResult = opBReg << shamtReg;
            FUNC_SRL:  execResult = opBReg >> shamtReg;
            FUNC_SRA:  execResult = WIDTH'($signed(opBReg) >>> shamtReg);
            default:   execIllegal = 1'b1;
        endcase
    end

    // Result and flags update only on the edge that enters DONE and then hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resultReg   <= '0;
            zeroReg     <= 1'b1;
            overflowReg <= 1'b0;
            illegalReg  <= 1'b0;
        end else if (state == EXEC) begin
            resultReg   <= execResult;
            zeroReg     <= (execResult == '0);
            overflowReg <= execOverflow;
            illegalReg  <= execIllegal;
        end else if ((state == COUNT) && leadFinished) begin
            resultReg   <= {{(WIDTH-CW){1'b0}}, leadCount};
            zeroReg     <= (leadCount == '0);
            overflowReg <= 1'b0;
            illegalReg  <= 1'b0;
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.result   = resultReg;
    assign bus.zero     = zeroReg;
    assign bus.overflow = overflowReg;
    assign bus.illegal  = illegalReg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request, keeping start high through cycle holdCycles, then check completion.
    task automatic runOp(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input int holdCycles,
                         input logic [31:0] expResult, input logic expZero, input logic expOvf,
                         input logic expIll, input int expLatency);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = f;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.shamt = sh;
        @(posedge clk);
        #1;
        cyc = 1;
        bus.start = (cyc <= holdCycles);
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
        while (!bus.done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.start = (cyc <= holdCycles);
        end
        check({tag, " latency"}, cyc, expLatency);
        check({tag, " result"}, bus.result, expResult);
        check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, expZero});
        check({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, expOvf});
        check({tag, " illegal"}, {31'd0, bus.illegal}, {31'd0, expIll});
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " idle after"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check({tag, " result hold"}, bus.result, expResult);
    endtask

    initial begin
        int cyc;
        errors    = 0;
        checks    = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.func  = 6'd0;
        bus.op_a  = 32'd0;
        bus.op_b  = 32'd0;
        bus.shamt = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset flags", {29'd0, bus.zero, bus.overflow, bus.illegal}, 32'b100);
        @(negedge clk);
        reset_n = 1'b1;

        runOp("add ovf",  6'b100000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 2);
        runOp("subu zero",6'b100011, 32'd5, 32'd5, 5'd0, 0, 32'd0, 1'b1, 1'b0, 1'b0, 2);
        runOp("sub ovf",  6'b100010, 32'h8000_0000, 32'h0000_0001, 5'd0, 0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2);
        runOp("addu wrap",6'b100001, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2);
        runOp("slt",      6'b101010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0, 32'd1, 1'b0, 1'b0, 1'b0, 2);
        runOp("sltu",     6'b101011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0, 32'd0, 1'b1, 1'b0, 1'b0, 2);
        runOp("nor",      6'b100111, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 0, 32'hF0F0_FF0F, 1'b0, 1'b0, 1'b0, 2);
        runOp("xor",      6'b100110, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 0, 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0, 2);
        runOp("sll",      6'b000000, 32'h1234_5678, 32'h0000_0001, 5'd31, 0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2);
        runOp("srl",      6'b000010, 32'd0, 32'h8000_0000, 5'd4, 0, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 2);
        runOp("sra",      6'b000011, 32'd0, 32'h8000_0000, 5'd4, 0, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 2);
        runOp("illegal",  6'b111111, 32'h1234_5678, 32'h1111_1111, 5'd0, 0, 32'd0, 1'b1, 1'b0, 1'b1, 2);
        runOp("clz 8",    6'b000111, 32'h00F0_0000, 32'd0, 5'd0, 0, 32'd8, 1'b0, 1'b0, 1'b0, 10);
        runOp("clz all",  6'b000111, 32'h0000_0000, 32'd0, 5'd0, 0, 32'd32, 1'b0, 1'b0, 1'b0, 33);
        runOp("clo none", 6'b111000, 32'h7FFF_FFFF, 32'd0, 5'd0, 0, 32'd0, 1'b1, 1'b0, 1'b0, 2);
        runOp("clo 3",    6'b111000, 32'hE123_4567, 32'd0, 5'd0, 0, 32'd3, 1'b0, 1'b0, 1'b0, 5);
        runOp("clz stall",6'b000111, 32'h0000_FFFF, 32'd0, 5'd0, 5, 32'd16, 1'b0, 1'b0, 1'b0, 18);
        repeat (3) @(posedge clk);
        #1;
        check("stall no restart", {30'd0, bus.busy, bus.done}, 32'd0);

        // Reset in the middle of a CLO of all ones.
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = 6'b111000;
        bus.op_a  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 5) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid reset busy", {31'd0, bus.busy}, 32'd0);
        check("mid reset done", {31'd0, bus.done}, 32'd0);
        check("mid reset result", bus.result, 32'd0);
        check("mid reset zero", {31'd0, bus.zero}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        runOp("clo all",  6'b111000, 32'hFFFF_FFFF, 32'd0, 5'd0, 0, 32'd32, 1'b0, 1'b0, 1'b0, 33);
        runOp("and after",6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 0, 32'h00F0_1234, 1'b0, 1'b0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
